// File: rtl/cromossomo_carregador_serial_pkg.sv
// Shared sizes and FSM state type for the byte-serial chromosome loader.
// The chromosome holds 25 logic elements of 15 bits plus 8 outputs of 6 bits.
package cromossomo_carregador_serial_pkg;

    localparam int N_LES      = 25;
    localparam int LE_BITS    = 15;
    localparam int N_OUTS     = 8;
    localparam int OUT_BITS   = 6;
    localparam int CHROM_BITS = N_LES * LE_BITS + N_OUTS * OUT_BITS;  // 423
    localparam int BYTE_W     = 8;
    localparam int N_BYTES    = (CHROM_BITS + BYTE_W - 1) / BYTE_W;   // 53
    localparam int CNT_W      = $clog2(N_BYTES + 1);                  // 6

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/cromossomo_carregador_serial.sv
// Byte-serial chromosome loader: assembles 53 data bytes in a shadow register and
// commits them to the active chromosome in one edge, only if the XOR checksum matches.
module cromossomo_carregador_serial
    import cromossomo_carregador_serial_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [BYTE_W-1:0]     byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [CHROM_BITS-1:0] cromossomo,
    output logic                  cromossomo_valid,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_error
);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      byte_cnt;
    logic [BYTE_W-1:0]     acc;
    logic [BYTE_W-1:0]     chk;
    logic [CHROM_BITS-1:0] shadow;
    logic                  xfer;
    logic                  last_byte;

    assign xfer      = byte_valid && byte_ready;
    assign last_byte = (byte_cnt == CNT_W'(N_BYTES));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves it holding a latch.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_next = LOAD;
            end
            LOAD: begin
                byte_ready = !load_start;
                if (byte_valid && !load_start && last_byte) state_next = CHECK;
            end
            CHECK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: the shadow is a plain register, not a RAM, so clearing it under reset is cheap and keeps outputs deterministic.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt         <= '0;
            acc              <= '0;
            chk              <= '0;
            shadow           <= '0;
            cromossomo       <= '0;
            cromossomo_valid <= 1'b0;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        byte_cnt <= '0;
                        acc      <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        byte_cnt <= '0;
                        acc      <= '0;
                    end else if (xfer) begin
                        if (last_byte) begin
                            chk <= byte_in;
                        end else begin
                            // Bit 7 of the final data byte has no home above bit 422; it only feeds the checksum.
                            for (int b = 0; b < CHROM_BITS; b++) begin
                                if (b / BYTE_W == int'(byte_cnt)) shadow[b] <= byte_in[b % BYTE_W];
                            end
                            acc      <= acc ^ byte_in;
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (chk == acc) begin
                        cromossomo       <= shadow;
                        cromossomo_valid <= 1'b1;
                        load_done        <= 1'b1;
                    end else begin
                        load_error       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cromossomo_carregador_serial.sv
// Scoreboard bench for cromossomo_carregador_serial: each load pushes its expected
// outcome, which is popped and compared when load_done/load_error fires.
`timescale 1ns/1ps
module tb_cromossomo_carregador_serial;
    import cromossomo_carregador_serial_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load_start;
    logic [BYTE_W-1:0]     byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [CHROM_BITS-1:0] cromossomo;
    logic                  cromossomo_valid;
    logic                  busy;
    logic                  load_done;
    logic                  load_error;

    cromossomo_carregador_serial dut (
        .clk              (clk),
        .rst              (rst),
        .load_start       (load_start),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .cromossomo       (cromossomo),
        .cromossomo_valid (cromossomo_valid),
        .busy             (busy),
        .load_done        (load_done),
        .load_error       (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                  is_err;
        logic [CHROM_BITS-1:0] chrom;
        logic                  valid;
    } exp_t;

    exp_t                  sb[$];
    logic [BYTE_W-1:0]     data_q [N_BYTES];
    logic [CHROM_BITS-1:0] model_chrom;
    logic                  model_valid;
    int                    n_cmp;
    int                    n_err;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic idle_gap(input int n, input string name);
        byte_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_cmp++;
            if (byte_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s gap_ready: got %b want 1", name, byte_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [BYTE_W-1:0] b, input string name);
        bit ok = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s accept_timeout: byte_ready never 1 (want 1)", name);
        end
    endtask

    task automatic wait_outcome(input string name);
        exp_t e;
        int   seen_at = -1;
        for (int i = 0; i < 6 && seen_at < 0; i++) begin
            @(negedge clk);
            if (load_done || load_error) seen_at = i;
        end
        n_cmp++;
        if (seen_at < 0) begin
            n_err++;
            $display("FAIL %s outcome_timeout: no load_done/load_error (want one)", name);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (seen_at !== 1) begin
                n_err++;
                $display("FAIL %s latency: got %0d want 1", name, seen_at);
            end
            n_cmp++;
            if (load_error !== e.is_err || load_done !== !e.is_err) begin
                n_err++;
                $display("FAIL %s kind: got done=%b err=%b want done=%b err=%b",
                         name, load_done, load_error, !e.is_err, e.is_err);
            end
            n_cmp++;
            if (cromossomo !== e.chrom) begin
                n_err++;
                $display("FAIL %s cromossomo: got %h want %h", name, cromossomo, e.chrom);
            end
            n_cmp++;
            if (cromossomo_valid !== e.valid) begin
                n_err++;
                $display("FAIL %s valid: got %b want %b", name, cromossomo_valid, e.valid);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (load_done !== 1'b0 || load_error !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_pulse: got done=%b err=%b busy=%b want 0 0 0",
                     name, load_done, load_error, busy);
        end
        @(posedge clk); #1;
    endtask

    // Pushes the expected outcome of a load of data_q + chk, drives it, then drains it.
    task automatic load_bytes(input logic [BYTE_W-1:0] chk, input bit do_start,
                              input int max_gap, input string name);
        exp_t                  e;
        logic [BYTE_W-1:0]     x = '0;
        logic [CHROM_BITS-1:0] c;
        for (int k = 0; k < N_BYTES; k++) x ^= data_q[k];
        for (int b = 0; b < CHROM_BITS; b++) c[b] = data_q[b / 8][b % 8];
        if (x == chk) begin
            model_chrom = c;
            model_valid = 1'b1;
            e.is_err    = 1'b0;
        end else begin
            e.is_err    = 1'b1;
        end
        e.chrom = model_chrom;
        e.valid = model_valid;
        sb.push_back(e);
        if (do_start) start_load();
        for (int k = 0; k < N_BYTES; k++) begin
            if (max_gap > 0) idle_gap($urandom_range(max_gap, 0), name);
            send_byte(data_q[k], name);
        end
        if (max_gap > 0) idle_gap($urandom_range(max_gap, 0), name);
        send_byte(chk, name);
        wait_outcome(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_in    = '0;
        model_chrom = '0;
        model_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cromossomo !== '0 || cromossomo_valid !== 1'b0 || load_done !== 1'b0 ||
            load_error !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b done=%b err=%b busy=%b ready=%b crom_nz=%b want all 0",
                     cromossomo_valid, load_done, load_error, busy, byte_ready, |cromossomo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zeros();
        for (int k = 0; k < N_BYTES; k++) data_q[k] = 8'h00;
        load_bytes(8'h00, 1'b1, 0, "zeros");
    endtask

    task automatic test_counting();
        for (int k = 0; k < N_BYTES; k++) data_q[k] = 8'(k);
        load_bytes(8'h34, 1'b1, 0, "counting");
        n_cmp++;
        if (cromossomo[7:0] !== 8'h00 || cromossomo[15:8] !== 8'h01 || cromossomo[422:416] !== 7'h34) begin
            n_err++;
            $display("FAIL counting_fields: got %h %h %h want 00 01 34",
                     cromossomo[7:0], cromossomo[15:8], cromossomo[422:416]);
        end
    endtask

    task automatic test_bad_checksum();
        for (int k = 0; k < N_BYTES; k++) data_q[k] = 8'(k);
        load_bytes(8'h35, 1'b1, 0, "bad_checksum");
    endtask

    task automatic test_restart();
        start_load();
        for (int k = 0; k < 10; k++) send_byte(8'h5A, "restart_pre");
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        @(negedge clk);
        n_cmp++;
        if (byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL restart_ready: got %b want 0", byte_ready);
        end
        n_cmp++;
        if (cromossomo !== model_chrom) begin
            n_err++;
            $display("FAIL restart_crom_kept: got %h want %h", cromossomo, model_chrom);
        end
        @(posedge clk); #1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        for (int k = 0; k < N_BYTES; k++) data_q[k] = 8'hFF;
        load_bytes(8'hFF, 1'b0, 0, "restart_ones");
        n_cmp++;
        if (cromossomo !== {CHROM_BITS{1'b1}}) begin
            n_err++;
            $display("FAIL ones_value: got %h want all ones", cromossomo);
        end
    endtask

    task automatic test_gaps();
        for (int k = 0; k < N_BYTES; k++) data_q[k] = 8'(k);
        load_bytes(8'h34, 1'b1, 5, "gaps");
    endtask

    task automatic test_reset_midload();
        start_load();
        for (int k = 0; k < 30; k++) send_byte(8'(k + 7), "midload");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_chrom = '0;
        model_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cromossomo !== '0 || cromossomo_valid !== 1'b0 || busy !== 1'b0 ||
            load_done !== 1'b0 || load_error !== 1'b0) begin
            n_err++;
            $display("FAIL midload_reset: got valid=%b busy=%b done=%b err=%b crom_nz=%b want all 0",
                     cromossomo_valid, busy, load_done, load_error, |cromossomo);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 23; k++) begin
            byte_valid = 1'b1;
            byte_in    = 8'(k);
            @(negedge clk);
            n_cmp++;
            if (byte_ready !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_ignore: got ready=%b busy=%b want 0 0", byte_ready, busy);
            end
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cromossomo !== '0 || cromossomo_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_commit: got valid=%b crom_nz=%b want 0 0", cromossomo_valid, |cromossomo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < N_BYTES; k++) data_q[k] = 8'($urandom);
        load_bytes(8'h00, 1'b1, 0, "b2b_first");
        load_bytes(8'h00, 1'b1, 0, "b2b_second");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_zeros();
        test_counting();
        test_bad_checksum();
        test_restart();
        test_gaps();
        test_reset_midload();
        test_counting();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cromossomo_carregador_serial.md
Name: cromossomo_carregador_serial

Overview:
Byte-serial loader that builds the 423-bit chromosome consumed by the phenotype decoder.
- Receives 53 data bytes plus one XOR checksum byte over a valid/ready byte interface.
- Assembles them in a shadow register.
- Commits the shadow to the active chromosome output atomically, and only when the checksum matches.
- The decoder therefore never sees a partially loaded or corrupted chromosome.

Parameters:
- CHROM_BITS, 423, active chromosome width (25 LEs x 15 bits + 8 outputs x 6 bits).
- BYTE_W, 8, serial byte width.
- N_BYTES, derived localparam = ceil(CHROM_BITS/BYTE_W) = 53, data bytes per load.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins a new load.
- byte_in  in  8  serial data/checksum byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts byte_in this cycle.
- cromossomo  out  423  active chromosome, to the phenotype decoder.
- cromossomo_valid  out  1  at least one successful commit since reset.
- busy  out  1  state is not IDLE.
- load_done  out  1  one-cycle pulse on successful commit.
- load_error  out  1  one-cycle pulse on checksum mismatch.

Behaviour:
- Reset values: cromossomo=0, cromossomo_valid=0, load_done=0, load_error=0, busy=0, state=IDLE, byte counter=0, shadow=0, checksum accumulator=0.
- Reset wins over every other input, including in mid-load. A partial shadow is discarded and never committed.
- States: IDLE, LOAD, CHECK.
- IDLE:
  - byte_ready=0.
  - load_start -> LOAD; byte counter=0, accumulator=0.
  - byte_valid alone is ignored.
- LOAD:
  - byte_ready = !load_start (combinational).
  - A transfer occurs when byte_valid && byte_ready.
  - Data byte k (k=0..52) is written to shadow[8k+7:8k] and XORed into the accumulator.
  - For k=52, bits 6:0 go to shadow[422:416]. Bit 7 is discarded from the shadow but still XORed into the accumulator.
  - Transfer with counter=53 is the checksum byte: it is latched and the state goes to CHECK. The counter does not advance past 53.
  - load_start in LOAD restarts: counter=0, accumulator=0, any byte offered that cycle is not accepted, and the active cromossomo is unchanged.
  - No timeout. The loader waits indefinitely between bytes; gaps in byte_valid are legal.
- CHECK (exactly one cycle):
  - byte_ready=0; load_start is ignored.
  - If the latched checksum equals the accumulator: cromossomo <= shadow, cromossomo_valid <= 1, load_done pulses.
  - Otherwise load_error pulses; cromossomo and cromossomo_valid are unchanged.
  - Next state is always IDLE.
- Latency: checksum byte accepted at edge E -> cromossomo updated and load_done/load_error asserted after edge E+1, for one cycle. Minimum load is 54 accepted bytes plus 1 cycle.
- load_done and load_error are registered and mutually exclusive.
- cromossomo changes only on a successful CHECK cycle, updating all 423 bits in the same edge.
- busy=1 in LOAD and CHECK.
- Arithmetic: the counter is 6 bits, covering 0..53, with no wrap.

Decomposition:
- Shared package:
  - CHROM_BITS=423, N_LES=25, LE_BITS=15, N_OUTS=8, OUT_BITS=6, BYTE_W=8, N_BYTES=53.
  - A state enum {IDLE, LOAD, CHECK}.
- No sub-module. The shift/index write, XOR accumulator and 3-state FSM sit in one module.

Test Plan:
- rst pulse, then 53 bytes of 0x00 and checksum 0x00 -> load_done one cycle after checksum accept; cromossomo=0; cromossomo_valid=1; load_error stays 0.
- Byte k = k (0x00..0x34), checksum 0x34 -> load_done; cromossomo[7:0]=0x00, [15:8]=0x01, [422:416]=0x34.
- Same data, checksum 0x35 -> load_error one cycle; cromossomo and cromossomo_valid keep the previous values; state returns to IDLE.
- After 10 bytes, pulse load_start with byte_valid high -> that byte is not accepted (byte_ready=0). A fresh 53+1 byte load of 0xFF with checksum 0xFF (odd count) -> load_done; cromossomo = all ones.
- Random byte_valid gaps of 0..5 cycles in a valid load -> same cromossomo result as the gapless load; byte_ready is high throughout LOAD except on load_start cycles.
- Assert rst after 30 bytes -> all outputs return to reset values next edge; the subsequent partial byte stream in IDLE is ignored (byte_ready=0, busy=0).
